// File: rtl/ysyx_bus_pkg.sv
// Shared encodings for the IFU/LSU memory bus arbiter.
package ysyx_bus_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_IFU_AR = 3'd1,
    ARB_IFU_R  = 3'd2,
    ARB_LSU_AR = 3'd3,
    ARB_LSU_R  = 3'd4,
    ARB_LSU_W  = 3'd5
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam int STRB_W = 8;

  // Fetches are always a full 32-bit word.
  localparam logic [STRB_W-1:0] IFU_RSTRB = 8'h0F;

endpackage

// File: rtl/ysyx_bus_watchdog.sv
// Open-transaction cycle counter; expire pulses in the TIMEOUT-th enabled cycle.
module ysyx_bus_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // The count lags the open-cycle number by one, so LAST marks cycle TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_bus_arbiter.sv
// Shares one memory bus master between IFU fetches and LSU loads/stores,
// one transaction at a time, with starvation guard and hang watchdog.
module ysyx_bus_arbiter
  import ysyx_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [STRB_W-1:0] lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_rvalid_o,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic              lsu_wvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [STRB_W-1:0] lsu_wstrb,
  output logic              lsu_wready_o,
  output logic [ADDR_W-1:0] bus_araddr_o,
  output logic [ADDR_W-1:0] bus_awaddr_o,
  output logic              bus_arvalid_o,
  output logic [STRB_W-1:0] bus_rstrb_o,
  output logic [STRB_W-1:0] bus_wstrb_o,
  input  logic              bus_arready,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic              bus_awvalid_o,
  output logic              bus_wvalid_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_wready,
  output logic              err_o
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    return (v == SC_MAX) ? v : v + 1'b1;
  endfunction

  arb_state_t        state_q;
  owner_t            owner_q;
  logic [SC_W-1:0]   starve_q;
  logic              err_q;
  logic              arvalid_q;
  logic              wvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [STRB_W-1:0] rstrb_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] wdata_q;

  logic in_ar, in_r, in_w;
  logic bus_done, wd_expire, timeout_fire, done;
  logic ifu_forced, store_req, grant_ifu, grant_store, grant_load;
  logic [DATA_W-1:0] rdata_fwd;

  assign in_ar = (state_q == ARB_IFU_AR) || (state_q == ARB_LSU_AR);
  assign in_r  = (state_q == ARB_IFU_R)  || (state_q == ARB_LSU_R);
  assign in_w  = (state_q == ARB_LSU_W);

  // A genuine bus response in the expiry cycle wins over the timeout.
  assign bus_done     = (in_ar && bus_arready && bus_rvalid) ||
                        (in_r && bus_rvalid) || (in_w && bus_wready);
  assign timeout_fire = wd_expire && !bus_done;
  assign done         = (bus_done || timeout_fire) && !rst;

  assign ifu_forced  = ifu_arvalid && (starve_q == SC_MAX);
  assign store_req   = lsu_awvalid && lsu_wvalid;
  assign grant_ifu   = ifu_forced || (ifu_arvalid && !store_req && !lsu_arvalid);
  assign grant_store = !ifu_forced && store_req;
  assign grant_load  = !ifu_forced && !store_req && lsu_arvalid;

  ysyx_bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q != ARB_IDLE),
    .clr   (state_q == ARB_IDLE),
    .expire(wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_IFU;
      starve_q  <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      rstrb_q   <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (grant_ifu) begin
            state_q   <= ARB_IFU_AR;
            owner_q   <= OWN_IFU;
            araddr_q  <= ifu_araddr;
            rstrb_q   <= IFU_RSTRB;
            arvalid_q <= 1'b1;
            starve_q  <= '0;
          end else if (grant_store) begin
            state_q  <= ARB_LSU_W;
            owner_q  <= OWN_LSU;
            awaddr_q <= lsu_awaddr;
            wdata_q  <= lsu_wdata;
            wstrb_q  <= lsu_wstrb;
            wvalid_q <= 1'b1;
            if (ifu_arvalid) starve_q <= sat_inc(starve_q);
          end else if (grant_load) begin
            state_q   <= ARB_LSU_AR;
            owner_q   <= OWN_LSU;
            araddr_q  <= lsu_araddr;
            rstrb_q   <= lsu_rstrb;
            arvalid_q <= 1'b1;
            if (ifu_arvalid) starve_q <= sat_inc(starve_q);
          end
        end
        ARB_IFU_AR, ARB_LSU_AR: begin
          if (bus_done || timeout_fire) begin
            state_q   <= ARB_IDLE;
            arvalid_q <= 1'b0;
          end else if (bus_arready) begin
            state_q   <= (state_q == ARB_IFU_AR) ? ARB_IFU_R : ARB_LSU_R;
            arvalid_q <= 1'b0;
          end
        end
        ARB_IFU_R, ARB_LSU_R: begin
          if (bus_done || timeout_fire) state_q <= ARB_IDLE;
        end
        ARB_LSU_W: begin
          if (bus_done || timeout_fire) begin
            state_q  <= ARB_IDLE;
            wvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          arvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
        end
      endcase
      if (timeout_fire) err_q <= 1'b1;
    end
  end

  assign rdata_fwd    = timeout_fire ? '0 : bus_rdata;
  assign ifu_rvalid_o = done && (owner_q == OWN_IFU);
  assign lsu_rvalid_o = done && (owner_q == OWN_LSU) && !in_w;
  assign lsu_wready_o = done && in_w;
  assign ifu_rdata_o  = ifu_rvalid_o ? rdata_fwd : '0;
  assign lsu_rdata_o  = lsu_rvalid_o ? rdata_fwd : '0;

  assign bus_araddr_o  = araddr_q;
  assign bus_awaddr_o  = awaddr_q;
  assign bus_arvalid_o = arvalid_q;
  assign bus_rstrb_o   = rstrb_q;
  assign bus_wstrb_o   = wstrb_q;
  assign bus_awvalid_o = wvalid_q;
  assign bus_wvalid_o  = wvalid_q;
  assign bus_wdata_o   = wdata_q;
  assign err_o         = err_q;

endmodule
